// File: rtl/game_master_sm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : State encodings and shared sizing helpers for game_master_sm.
// Revision : 1.0
// ============================================================================
package game_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    WIN   = 3'd2,
    LOSE  = 3'd3,
    PAUSE = 3'd4
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_master_sm_if.sv
`default_nettype none
// ============================================================================
// Module   : game_master_sm_if
// Purpose  : Button, score and status bundle between the game core and its
//            environment (master = environment, slave = game core).
// Revision : 1.0
// ============================================================================
interface game_master_sm_if
  import game_pkg::*;
#(
  parameter int SCORE_W  = 4,
  parameter int N_LEVELS = 4
) ();

  localparam int LEVEL_W = clog2_min1(N_LEVELS);

  logic               LEFT;
  logic               RIGHT;
  logic               UP;
  logic               DOWN;
  logic               PAUSE_BTN;
  logic               COLLISION;
  logic [SCORE_W-1:0] SCORE_COUNT;
  logic [STATE_W-1:0] STATE;
  logic [LEVEL_W-1:0] LEVEL;
  logic               GAME_START;

  modport master (
    output LEFT, RIGHT, UP, DOWN, PAUSE_BTN, COLLISION, SCORE_COUNT,
    input  STATE, LEVEL, GAME_START
  );

  modport slave (
    input  LEFT, RIGHT, UP, DOWN, PAUSE_BTN, COLLISION, SCORE_COUNT,
    output STATE, LEVEL, GAME_START
  );

endinterface
`default_nettype wire

// File: rtl/game_master_sm_btn_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge
// Purpose  : 1-bit rising-edge detector against a registered history bit.
// Revision : 1.0
// ============================================================================
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= btn_i;
    end
  end

  // A button held through reset still reports one edge once reset releases.
  assign rise_o = btn_i & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/game_master_sm.sv
`default_nettype none
// ============================================================================
// Module   : game_master_sm
// Purpose  : Snake game master FSM: start, level progression, win/lose hold.
//            Optional PAUSE state built when GAME_MASTER_PAUSE_EN is defined.
// Revision : 1.0
// ============================================================================
module game_master_sm
  import game_pkg::*;
#(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 10,
  parameter int LEVEL_STEP  = 3,
  parameter int N_LEVELS    = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  game_master_sm_if.slave bus
);

  localparam int                 LEVEL_W   = clog2_min1(N_LEVELS);
  localparam int                 HOLD_W    = clog2_min1(HOLD_CYCLES + 1);
  localparam logic [SCORE_W:0]   WIN_THR   = (SCORE_W + 1)'(WIN_SCORE);
  localparam logic [SCORE_W:0]   STEP      = (SCORE_W + 1)'(LEVEL_STEP);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(N_LEVELS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

  logic [3:0] dir_raw;
  logic [3:0] dir_rise;
  logic       any_dir;

  assign dir_raw = {bus.LEFT, bus.RIGHT, bus.UP, bus.DOWN};

  for (genvar gi = 0; gi < 4; gi++) begin : g_dir
    btn_edge u_edge (
      .clk    (CLK),
      .rst_n  (RESET),
      .btn_i  (dir_raw[gi]),
      .rise_o (dir_rise[gi])
    );
  end

  assign any_dir = |dir_rise;

`ifdef GAME_MASTER_PAUSE_EN
  logic pause_rise;

  btn_edge u_pause_edge (
    .clk    (CLK),
    .rst_n  (RESET),
    .btn_i  (bus.PAUSE_BTN),
    .rise_o (pause_rise)
  );
`else
  logic unused_pause_btn;
  assign unused_pause_btn = bus.PAUSE_BTN;
`endif

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [SCORE_W:0]   thresh_q, thresh_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               start_q, start_d;
  logic [SCORE_W:0]   score;

  assign score = {1'b0, bus.SCORE_COUNT};

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= IDLE;
      level_q  <= '0;
      thresh_q <= STEP;
      hold_q   <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      thresh_q <= thresh_d;
      hold_q   <= hold_d;
      start_q  <= start_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    thresh_d = thresh_q;
    hold_d   = hold_q;
    start_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_dir) begin
          state_d  = PLAY;
          start_d  = 1'b1;
          level_d  = '0;
          thresh_d = STEP;
        end
      end

      PLAY: begin
        if ((score >= thresh_q) && (level_q < LEVEL_MAX)) begin
          level_d  = level_q + 1'b1;
          thresh_d = thresh_q + STEP;
        end
        if (bus.COLLISION) begin
          state_d = LOSE;
          hold_d  = '0;
        end else if (score >= WIN_THR) begin
          state_d = WIN;
          hold_d  = '0;
        end
`ifdef GAME_MASTER_PAUSE_EN
        else if (pause_rise) begin
          state_d = PAUSE;
        end
`endif
      end

      WIN, LOSE: begin
        if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
        // Edges before the hold expires are dropped, never remembered.
        if (any_dir && (hold_q == HOLD_MAX)) begin
          state_d = IDLE;
        end
      end

`ifdef GAME_MASTER_PAUSE_EN
      PAUSE: begin
        if (pause_rise) begin
          state_d = PLAY;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  assign bus.STATE      = state_q;
  assign bus.LEVEL      = level_q;
  assign bus.GAME_START = start_q;

endmodule
`default_nettype wire

// File: tb/tb_game_master_sm.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_master_sm
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            randomized stimulus against a behavioural reference model.
// Revision : 1.0
// ============================================================================
module tb_game_master_sm;

  localparam int SCORE_W     = 4;
  localparam int WIN_SCORE   = 10;
  localparam int LEVEL_STEP  = 3;
  localparam int N_LEVELS    = 4;
  localparam int HOLD_CYCLES = 8;
  localparam int LW          = 2;

`ifdef GAME_MASTER_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  // Button vector layout: {PAUSE, LEFT, RIGHT, UP, DOWN}
  localparam logic [4:0] B_N = 5'b00000;
  localparam logic [4:0] B_P = 5'b10000;
  localparam logic [4:0] B_L = 5'b01000;
  localparam logic [4:0] B_R = 5'b00100;
  localparam logic [4:0] B_U = 5'b00010;
  localparam logic [4:0] B_D = 5'b00001;

  logic CLK;
  logic RESET;

  game_master_sm_if #(.SCORE_W(SCORE_W), .N_LEVELS(N_LEVELS)) bus ();

  game_master_sm #(
    .SCORE_W     (SCORE_W),
    .WIN_SCORE   (WIN_SCORE),
    .LEVEL_STEP  (LEVEL_STEP),
    .N_LEVELS    (N_LEVELS),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: game rules expressed directly, level threshold derived
  // from the level number, end-screen time as an unbounded cycle count.
  int         m_state = 0;
  int         m_level = 0;
  int         m_end   = 0;
  bit         m_start = 1'b0;
  logic [4:0] m_prev  = 5'b0;

  task automatic model_clock(input bit rst_n, input logic [4:0] btn,
                             input bit col, input int sc);
    logic [4:0] rise;
    bit         any;
    int         nxt;
    rise = btn & ~m_prev;
    any  = |rise[3:0];
    nxt  = m_state;
    if (!rst_n) begin
      m_state = 0; m_level = 0; m_end = 0; m_start = 1'b0; m_prev = 5'b0;
      return;
    end
    m_start = 1'b0;
    case (m_state)
      0: if (any) begin nxt = 1; m_start = 1'b1; m_level = 0; end
      1: begin
        if (sc >= (m_level + 1) * LEVEL_STEP && m_level < N_LEVELS - 1)
          m_level = m_level + 1;
        if (col)                      nxt = 3;
        else if (sc >= WIN_SCORE)     nxt = 2;
        else if (PAUSE_EN && rise[4]) nxt = 4;
      end
      2, 3: if (any && m_end >= HOLD_CYCLES) nxt = 0;
      4: if (rise[4]) nxt = 1;
      default: nxt = 0;
    endcase
    if (nxt == m_state) m_end = m_end + 1;
    else                m_end = 0;
    m_state = nxt;
    m_prev  = btn;
  endtask

  task automatic cyc(input bit rst_n, input logic [4:0] btn, input bit col, input int sc);
    RESET           = rst_n;
    bus.PAUSE_BTN   = btn[4];
    bus.LEFT        = btn[3];
    bus.RIGHT       = btn[2];
    bus.UP          = btn[1];
    bus.DOWN        = btn[0];
    bus.COLLISION   = col;
    bus.SCORE_COUNT = SCORE_W'(sc);
    @(posedge CLK);
    model_clock(rst_n, btn, col, sc);
    #1;
  endtask

  task automatic chk(input string nm, input int st, input int lv, input bit gs);
    checks++;
    if (bus.STATE !== 3'(st) || bus.LEVEL !== LW'(lv) || bus.GAME_START !== gs) begin
      errors++;
      $display("FAIL %s: got state=%0d level=%0d start=%0b, expected state=%0d level=%0d start=%0b",
               nm, bus.STATE, bus.LEVEL, bus.GAME_START, st, lv, gs);
    end
  endtask

  typedef struct {
    bit         rst_n;
    logic [4:0] btn;
    bit         col;
    int         sc;
    int         st;
    int         lv;
    bit         gs;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  initial begin
    RESET = 1'b0;
    bus.LEFT = 1'b0; bus.RIGHT = 1'b0; bus.UP = 1'b0; bus.DOWN = 1'b0;
    bus.PAUSE_BTN = 1'b0; bus.COLLISION = 1'b0; bus.SCORE_COUNT = '0;

    tbl.push_back('{1'b0, B_N, 1'b0,  0, 0, 0, 1'b0, "reset"});
    tbl.push_back('{1'b1, B_N, 1'b0,  0, 0, 0, 1'b0, "idle_quiet"});
    tbl.push_back('{1'b1, B_L, 1'b0,  0, 1, 0, 1'b1, "start"});
    tbl.push_back('{1'b1, B_L, 1'b0,  0, 1, 0, 1'b0, "start_one_pulse"});
    tbl.push_back('{1'b1, B_N, 1'b0,  3, 1, 1, 1'b0, "level1"});
    tbl.push_back('{1'b1, B_N, 1'b0,  5, 1, 1, 1'b0, "below_thr6"});
    tbl.push_back('{1'b1, B_N, 1'b0,  6, 1, 2, 1'b0, "level2"});
    tbl.push_back('{1'b1, B_N, 1'b0,  9, 1, 3, 1'b0, "level3"});
    tbl.push_back('{1'b1, B_N, 1'b0,  9, 1, 3, 1'b0, "level_sat"});
    tbl.push_back('{1'b1, B_N, 1'b1, 10, 3, 3, 1'b0, "col_over_win"});

    foreach (tbl[i]) begin
      cyc(tbl[i].rst_n, tbl[i].btn, tbl[i].col, tbl[i].sc);
      chk(tbl[i].nm, tbl[i].st, tbl[i].lv, tbl[i].gs);
    end

    // LOSE hold window: edges at hold 4 and 7 dropped, edge at 8 restarts.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, B_N, 1'b0, 10); chk("lose_hold", 3, 3, 1'b0);
    end
    cyc(1'b1, B_U, 1'b0, 10); chk("early_up_h4", 3, 3, 1'b0);
    cyc(1'b1, B_N, 1'b0, 10); cyc(1'b1, B_N, 1'b0, 10);
    cyc(1'b1, B_U, 1'b0, 10); chk("early_up_h7", 3, 3, 1'b0);
    cyc(1'b1, B_N, 1'b0, 10); chk("lose_hold_sat", 3, 3, 1'b0);
    cyc(1'b1, B_U, 1'b0, 10); chk("restart_idle", 0, 3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, B_N, 1'b0, 0); chk("level_kept_idle", 0, 3, 1'b0);
    end

    // Start, hold LEFT, then ramp score to a win.
    cyc(1'b1, B_L, 1'b0, 0); chk("start2", 1, 0, 1'b1);
    for (int k = 0; k < 50; k++) begin
      cyc(1'b1, B_L, 1'b0, 0); chk("held_left", 1, 0, 1'b0);
    end
    for (int s = 1; s <= 10; s++) begin
      for (int k = 0; k < 5; k++) begin
        cyc(1'b1, B_N, 1'b0, s);
        if (s < WIN_SCORE) chk("ramp", 1, (s / 3 < 3) ? s / 3 : 3, 1'b0);
        else               chk("ramp_win", 2, 3, 1'b0);
      end
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, B_N, 1'b0, 10); chk("win_hold", 2, 3, 1'b0);
    end
    cyc(1'b1, B_N, 1'b0, 10);
    cyc(1'b1, B_N, 1'b0, 10);
    cyc(1'b1, B_N, 1'b0, 10);
    cyc(1'b1, B_R, 1'b0, 10); chk("win_restart", 0, 3, 1'b0);

    // Pause handling.
    cyc(1'b1, B_D, 1'b0, 0); chk("start3", 1, 0, 1'b1);
    cyc(1'b1, B_P, 1'b0, 0); chk("pause_enter", PAUSE_EN ? 4 : 1, 0, 1'b0);
    cyc(1'b1, B_N, 1'b0, 0); chk("pause_stay", PAUSE_EN ? 4 : 1, 0, 1'b0);
    if (PAUSE_EN) begin
      cyc(1'b1, B_N, 1'b1, 9);  chk("pause_ignore_col", 4, 0, 1'b0);
      cyc(1'b1, B_U, 1'b0, 10); chk("pause_ignore_dir", 4, 0, 1'b0);
      cyc(1'b1, B_P, 1'b0, 9);  chk("pause_exit", 1, 0, 1'b0);
      cyc(1'b1, B_N, 1'b0, 9);  chk("after_pause_lvl", 1, 1, 1'b0);
    end else begin
      cyc(1'b1, B_P, 1'b0, 0);  chk("pause_ignored", 1, 0, 1'b0);
    end

    // Reset mid-PLAY at level 2, then a button held across reset release.
    cyc(1'b1, B_N, 1'b0, 6);
    cyc(1'b1, B_N, 1'b0, 6);
    cyc(1'b1, B_N, 1'b0, 6); chk("play_level2", 1, 2, 1'b0);
    cyc(1'b0, B_N, 1'b0, 6); chk("reset_mid_play", 0, 0, 1'b0);
    cyc(1'b0, B_L, 1'b0, 0); chk("reset_held_btn", 0, 0, 1'b0);
    cyc(1'b1, B_L, 1'b0, 0); chk("held_through_reset", 1, 0, 1'b1);
    cyc(1'b1, B_N, 1'b1, 0); chk("lose_again", 3, 0, 1'b0);
    cyc(1'b1, B_N, 1'b0, 0);
    cyc(1'b0, B_N, 1'b0, 0); chk("reset_mid_hold", 0, 0, 1'b0);
    cyc(1'b1, B_R, 1'b0, 0); chk("start_after_hold_reset", 1, 0, 1'b1);

    // Randomized run against the reference model.
    begin
      int sc;
      sc = 0;
      cyc(1'b0, B_N, 1'b0, 0);
      for (int n = 0; n < 3000; n++) begin
        logic [4:0] b;
        bit         rn;
        bit         col;
        int         r;
        for (int i = 0; i < 5; i++) b[i] = ($urandom_range(0, 3) == 0);
        rn  = ($urandom_range(0, 299) != 0);
        col = ($urandom_range(0, 39) == 0);
        r   = $urandom_range(0, 19);
        if (r < 3 && sc < 15)       sc = sc + 1;
        else if (r == 3 && sc > 0)  sc = sc - 1;
        else if (r == 4)            sc = $urandom_range(0, 9);
        else if (r == 5)            sc = $urandom_range(0, 15);
        cyc(rn, b, col, sc);
        chk("random", m_state, m_level, m_start);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
